if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC, issues requests to a variable-latency instruction memory, and drives the IF/ID pipeline register (`instr_d`, `pc4_d`, `valid_d`) consumed by the decode stage. It is the receiving end of decode's `npc`/`npc_sel` redirect, applied with one architectural delay slot. A redirect that arrives while the delay-slot fetch is still outstanding is remembered until that fetch completes.

## Interface
- `RESET_PC`, 32'h0000_3000, PC of the first fetch after reset.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hazard-unit stall; 1 = IF/ID register must hold.
- `npc`  input  32  redirect target computed by decode.
- `npc_sel`  input  1  decode redirect request; valid only when `stall`=0 and the decode instruction is valid.
- `imem_req`  output  1  fetch request; held until acknowledged.
- `imem_addr`  output  32  word-aligned fetch address; stable while `imem_req`=1.
- `imem_ack`  input  1  memory returns `imem_rdata` this cycle. May be high in the same cycle as `imem_req` (zero-wait).
- `imem_rdata`  input  32  fetched instruction.
- `instr_d`  output  32  IF/ID instruction.
- `pc4_d`  output  32  IF/ID PC+4.
- `valid_d`  output  1  IF/ID entry holds a real instruction (0 = bubble).

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - FULL: fetched word is held in a skid buffer, `imem_req`=0.
- Advance: `adv` = ~`stall`. On `adv`, the IF/ID register loads:
  - the delivered word, if one is available this cycle (buffer in FULL, or `imem_ack` in FETCH); `valid_d`=1, `pc4_d`=pc+4 of that word;
  - otherwise a bubble: `valid_d`=0, `instr_d`=0, `pc4_d`=0.
- On `stall`, the IF/ID register holds all three outputs.
- FETCH transitions:
  - `imem_ack` & `adv`: deliver directly; pc ← next; stay in FETCH.
  - `imem_ack` & `stall`: capture word in buffer; go to FULL.
  - no ack: stay in FETCH, same address.
- FULL transitions:
  - `adv`: deliver buffer; pc ← next; go to FETCH.
  - `stall`: hold.
- Next-PC selection (delay slot): the word delivered in a given cycle is the delay slot of the instruction in decode.
  - If a delivery and `adv`&`npc_sel` coincide: next = `npc`.
  - Else if the redirect-pending flag is set at delivery: next = stored target; clear the flag.
  - Else: next = pc+4.
- Pending redirect: `adv`&`npc_sel` with no delivery in that cycle sets the pending flag and stores `npc` as the target. The in-flight or next fetch (the delay slot) still completes normally, then the target applies.
- `npc_sel` while the pending flag is set is a protocol violation. Flag it with an assertion; the stored target is not overwritten.
- PC arithmetic is modulo 2^32. pc 32'hFFFF_FFFC + 4 wraps to 0.
- `imem_addr` bits [1:0] are always 0. `npc` bits [1:0] are ignored (forced to 0).

## Timing
- Reset (async assert) sets:
  - pc=`RESET_PC`, state=FETCH, pending=0, buffer=0;
  - `valid_d`=0, `instr_d`=0, `pc4_d`=0;
  - `imem_req`=0 while reset is asserted.
- First clock after release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency and throughput: with zero-wait memory, one instruction per cycle. An instruction presented with `imem_ack` in cycle N appears on `instr_d` in cycle N+1.
- Redirect: branch in decode in cycle N (with `adv`) → delay slot in IF/ID at N+1 → target on `imem_addr` at N+1 (zero-wait).
- `imem_req`/`imem_addr` never change between request and ack.
- Reset mid-fetch: the outstanding request is abandoned, and any late `imem_ack` after reset release is not expected. Memory must drop requests on reset.

## Structure
- Shared package `if_pkg`:
  - `RESET_PC_DEFAULT`;
  - state enum {FETCH, FULL};
  - `BUBBLE` = 32'h0000_0000 (sll $0 encoding).
- One natural sub-module, `pc_next_sel`: combinational next-PC mux. Inputs: pc, npc, npc_sel/adv, pending flag and target. Output: next pc.
- PC, pending flag/target, skid buffer, state and IF/ID register live in `if_fetch`.

## Test plan
- Reset then zero-wait memory, no stalls: `imem_addr` = 0x3000, 0x3004, 0x3008… one per cycle; `pc4_d` = 0x3004, 0x3008… with `valid_d`=1 from the second cycle.
- Memory ack delayed 3 cycles, `stall`=0: `imem_addr` holds 0x3000 for 3 cycles; IF/ID shows 3 bubbles (`valid_d`=0, `instr_d`=0), then the word with `pc4_d`=0x3004.
- `stall`=1 for 2 cycles coincident with ack at 0x3008: state goes FULL and `imem_req`=0; `instr_d` unchanged during the stall; after release, the 0x3008 word is delivered and the fetch resumes at 0x300C.
- `npc_sel`=1, `npc`=0x3100 during delivery of the word at 0x3010 (zero-wait): IF/ID gets the 0x3010 word (`pc4_d`=0x3014); the next `imem_addr` = 0x3100.
- `npc_sel`=1, `npc`=0x3200 while the fetch of 0x3014 waits 2 cycles: pending is set; the 0x3014 word is delivered when acked; the next `imem_addr` = 0x3200; pending clears.
- Assert `reset` low mid-wait with `imem_req`=1: `imem_req`=0 and `valid_d`=0 immediately (async); after release, `imem_addr`=0x3000.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, FSM states, bubble encoding.
package if_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] BUBBLE           = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: same-cycle redirect, else pending target, else pc+4.
// Zero latency; the caller applies the result only on a delivered, advancing word.
module pc_next_sel (
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic        redir,
  input  logic        pend,
  input  logic [31:0] pend_tgt,
  output logic [31:0] pc_nxt
);
  always_comb begin
    pc_nxt = pc + 32'd4;
    if (redir) begin
      pc_nxt = {npc[31:2], 2'b00};
    end else if (pend) begin
      pc_nxt = pend_tgt;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// MIPS fetch stage: drives imem requests and the IF/ID register, one word per cycle with zero-wait memory.
// A stall at ack time parks the word in a skid buffer and drops imem_req until decode advances.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        npc_sel,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc4_d,
  output logic        valid_d
);
  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  skid;
  logic         pend;
  logic [31:0]  pend_tgt;
  logic         req_en;
  logic         adv;
  logic         fetching;
  logic         deliver;
  logic [31:0]  word;
  logic [31:0]  pc_nxt;

  assign adv       = ~stall;
  // req_en keeps imem_req low until the first clock edge after reset release.
  assign fetching  = (state == FETCH) && req_en;
  assign deliver   = (state == FULL) || (fetching && imem_ack);
  assign word      = (state == FULL) ? skid : imem_rdata;
  assign imem_req  = fetching;
  assign imem_addr = pc;

  pc_next_sel u_pc_next_sel (
    .pc       (pc),
    .npc      (npc),
    .redir    (adv && npc_sel),
    .pend     (pend),
    .pend_tgt (pend_tgt),
    .pc_nxt   (pc_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      skid     <= BUBBLE;
      pend     <= 1'b0;
      pend_tgt <= '0;
      req_en   <= 1'b0;
      instr_d  <= BUBBLE;
      pc4_d    <= '0;
      valid_d  <= 1'b0;
    end else begin
      req_en <= 1'b1;

      if (adv) begin
        if (deliver) begin
          instr_d <= word;
          pc4_d   <= pc + 32'd4;
          valid_d <= 1'b1;
        end else begin
          instr_d <= BUBBLE;
          pc4_d   <= '0;
          valid_d <= 1'b0;
        end
      end

      case (state)
        FETCH: begin
          if (fetching && imem_ack && !adv) begin
            skid  <= imem_rdata;
            state <= FULL;
          end
        end
        FULL: begin
          if (adv) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase

      if (deliver && adv) begin
        pc   <= pc_nxt;
        pend <= 1'b0;
      end else if (adv && npc_sel && !pend) begin
        // Branch seen before its delay slot arrived: apply target after that word.
        pend     <= 1'b1;
        pend_tgt <= {npc[31:2], 2'b00};
      end
    end
  end

  a_single_pending_redirect: assert property (
    @(posedge clk) disable iff (!reset) !(adv && npc_sel && pend)
  );
endmodule
